// File: rtl/if_fetch_unit_pkg.sv
// Shared pipeline definitions for the instruction fetch stage.
// Contents: instruction width, NOP encoding (addi x0,x0,0), PC increment.
package if_fetch_unit_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_INC    = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer holding {pc, instruction} entries.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   push, push_data     write an entry (ignored when full or flushing)
//   pop                 consume the head entry (ignored when empty)
//   flush               empty the buffer; wins over push and pop
//   count               number of valid entries (0..DEPTH)
//   head_data           entry at the head (meaningful when head_valid)
//   head_valid          buffer is not empty
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head_data,
  output logic                     head_valid
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign head_valid = (count != '0);
  assign head_data  = mem[rd_ptr];
  assign do_push    = push && (count != FULL_CNT);
  assign do_pop     = pop && head_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: the head is only observed when count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order word requests
// to instruction memory, buffers responses with their PCs and feeds IF/ID.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   stall                          downstream hold (same as IF/ID stall)
//   redirect_valid, redirect_pc    branch/jump/trap target (bits [1:0] ignored)
//   imem_req_valid/ready/addr      request channel (valid/ready)
//   imem_resp_valid/data           in-order response, no backpressure
//   pc_out, instruction_out        FIFO head (0 / NOP when empty)
//   valid_out                      FIFO head is valid
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int unsigned      FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [XLEN-1:0]     imem_req_addr,
  input  logic                imem_resp_valid,
  input  logic [INSTR_W-1:0]  imem_resp_data,
  output logic [XLEN-1:0]     pc_out,
  output logic [INSTR_W-1:0]  instruction_out,
  output logic                valid_out
);

  localparam int unsigned     CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned     WIDTH   = XLEN + INSTR_W;
  localparam logic [CW:0]     DEPTH_W = (CW+1)'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(PC_INC);

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  resp_pc;
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    drop_cnt;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      credit_used;
  logic [XLEN-1:0]  redirect_tgt;
  logic             accept;
  logic             keep;
  logic             pop;
  logic [WIDTH-1:0] head_data;
  logic             head_valid;

  // Credits cover both in-flight requests and buffered entries, so every
  // response always has a FIFO slot even while decode is stalled.
  assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid = !reset && !redirect_valid && (credit_used < DEPTH_W);
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign redirect_tgt   = redirect_pc & ~XLEN'(3);

  // Responses arriving during a redirect, or owed to a flushed stream, are dropped.
  assign keep = imem_resp_valid && !redirect_valid && (drop_cnt == '0);
  assign pop  = valid_out && !stall && !redirect_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_VECTOR;
      resp_pc     <= RESET_VECTOR;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      case ({accept, imem_resp_valid})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
      if (redirect_valid) begin
        fetch_pc <= redirect_tgt;
        resp_pc  <= redirect_tgt;
        // Everything still in flight after this cycle belongs to the old stream.
        drop_cnt <= outstanding - CW'(imem_resp_valid);
      end else begin
        if (accept) fetch_pc <= fetch_pc + PC_STEP;
        if (keep)   resp_pc  <= resp_pc + PC_STEP;
        if (imem_resp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (keep),
    .push_data  ({resp_pc, imem_resp_data}),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (fifo_count),
    .head_data  (head_data),
    .head_valid (head_valid)
  );

  assign valid_out       = head_valid;
  assign pc_out          = head_valid ? head_data[WIDTH-1:INSTR_W] : '0;
  assign instruction_out = head_valid ? head_data[INSTR_W-1:0] : NOP_INSTR;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: memory responder with variable
// latency, expected instruction stream kept as a queue of PCs, monitor that
// checks every consumed instruction, request addresses, hold behaviour and
// redirect latency.
module tb_if_fetch_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RV    = 32'hFFFF_FFF0;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        valid_out;

  if_fetch_unit #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RV),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .valid_out       (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] stream_pc;
  logic [31:0] exp_req_addr;
  int          last_due;
  int          lat;
  int          cyc;
  int          pop_count;
  int          idle;
  int          redir_cyc;
  logic        lat_armed;
  logic        lat_check_en;
  int          n_checks;
  int          n_fail;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic topup();
    while (exp_q.size() < 8) begin
      exp_q.push_back(stream_pc);
      stream_pc = stream_pc + 32'd4;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    stream_pc    = RV;
    exp_req_addr = RV;
    lat_armed    = 1'b0;
    topup();
  endtask

  // One cycle of stimulus; a redirect restarts the expected stream at the target.
  task automatic drive(input logic s, input logic r, input logic rv, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    stall          = s;
    imem_req_ready = r;
    redirect_valid = rv;
    redirect_pc    = rv ? tgt : $urandom;
    if (rv) begin
      exp_q.delete();
      stream_pc    = tgt & 32'hFFFF_FFFC;
      exp_req_addr = tgt & 32'hFFFF_FFFC;
      redir_cyc    = cyc;
      lat_armed    = lat_check_en;
    end
    topup();
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Memory responder: in order, at most one response per cycle.
  always begin
    @(posedge clk);
    #1;
    if (reset) begin
      mem_q.delete();
      last_due        = 0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mem_q[0].addr);
      mem_q.delete(0);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
  end

  // Monitor
  logic        prev_wait;
  logic [31:0] prev_addr;
  logic        prev_hold;
  logic [31:0] prev_pc;
  logic [31:0] prev_ins;

  always @(negedge clk) begin
    if (reset) begin
      prev_wait = 1'b0;
      prev_hold = 1'b0;
      idle      = 0;
    end else begin
      if (!valid_out) begin
        check("empty_pc", pc_out, 32'h0);
        check("empty_ins", instruction_out, NOP);
      end
      if (redirect_valid) check("no_req_on_redirect", 32'(imem_req_valid), 32'd0);
      if (prev_wait && !redirect_valid) begin
        check("req_hold_valid", 32'(imem_req_valid), 32'd1);
        check("req_hold_addr", imem_req_addr, prev_addr);
      end
      if (prev_hold) begin
        check("stall_hold_valid", 32'(valid_out), 32'd1);
        check("stall_hold_pc", pc_out, prev_pc);
        check("stall_hold_ins", instruction_out, prev_ins);
      end
      if (imem_req_valid && imem_req_ready) begin
        req_t r;
        int   due;
        check("req_addr", imem_req_addr, exp_req_addr);
        exp_req_addr = exp_req_addr + 32'd4;
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        r.addr = imem_req_addr;
        r.due  = due;
        mem_q.push_back(r);
      end
      if (lat_armed && cyc > redir_cyc && valid_out) begin
        check("redirect_latency", 32'(cyc - redir_cyc), 32'(2 + lat));
        lat_armed = 1'b0;
      end
      if (valid_out && !stall && !redirect_valid) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("pop_pc", pc_out, e);
        check("pop_ins", instruction_out, mem_word(e));
        pop_count++;
        idle = 0;
      end else if (!stall && !redirect_valid) begin
        idle++;
        if (idle > 40) begin
          n_checks++;
          n_fail++;
          $display("FAIL fetch_progress: %0d cycles without output, limit 40 (cycle %0d)", idle, cyc);
          idle = 0;
        end
      end
      prev_wait = imem_req_valid && !imem_req_ready;
      prev_addr = imem_req_addr;
      prev_hold = valid_out && stall && !redirect_valid;
      prev_pc   = pc_out;
      prev_ins  = instruction_out;
    end
  end

  initial begin
    int p0;
    n_checks = 0; n_fail = 0; cyc = 0; pop_count = 0; idle = 0;
    last_due = 0; redir_cyc = 0; lat = 1; lat_check_en = 1'b0;
    prev_wait = 1'b0; prev_hold = 1'b0; prev_addr = '0; prev_pc = '0; prev_ins = '0;
    reset = 1'b1; stall = 1'b0; imem_req_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_resp_valid = 1'b0; imem_resp_data = '0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("reset_valid_out", 32'(valid_out), 32'd0);
    check("reset_pc_out", pc_out, 32'h0);
    check("reset_ins", instruction_out, NOP);
    check("reset_req_valid", 32'(imem_req_valid), 32'd0);

    // Release: first request this cycle, so first valid_out after 1+L cycles.
    reset        = 1'b0;
    lat_check_en = 1'b1;
    redir_cyc    = cyc - 1;
    lat_armed    = 1'b1;
    repeat (5) drive(1'b0, 1'b1, 1'b0, '0);
    p0 = pop_count;
    repeat (12) drive(1'b0, 1'b1, 1'b0, '0);
    check("throughput", 32'(pop_count - p0), 32'd12);

    // Decode stall: credits run out, head held.
    repeat (6) drive(1'b1, 1'b1, 1'b0, '0);
    check("credits_exhausted", 32'(imem_req_valid), 32'd0);
    repeat (10) drive(1'b0, 1'b1, 1'b0, '0);

    // Memory not ready for 3 cycles.
    repeat (3) drive(1'b0, 1'b0, 1'b0, '0);
    repeat (8) drive(1'b0, 1'b1, 1'b0, '0);

    // L=3 with requests in flight, unaligned redirect.
    lat = 3;
    repeat (8) drive(1'b0, 1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0103);
    repeat (12) drive(1'b0, 1'b1, 1'b0, '0);

    // Back-to-back redirects.
    lat = 1;
    repeat (6) drive(1'b0, 1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0200);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0400);
    repeat (10) drive(1'b0, 1'b1, 1'b0, '0);

    // Randomized traffic with varying latency.
    lat_check_en = 1'b0;
    for (int b = 0; b < 40; b++) begin
      lat = $urandom_range(4, 1);
      for (int i = 0; i < 15; i++)
        drive($urandom_range(99) < 30, $urandom_range(99) < 70,
              $urandom_range(99) < 5, $urandom);
    end

    // Reset with a full buffer.
    lat = 1;
    repeat (10) drive(1'b0, 1'b1, 1'b0, '0);
    repeat (10) drive(1'b1, 1'b1, 1'b0, '0);
    check("full_before_reset", 32'(valid_out), 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_valid_out", 32'(valid_out), 32'd0);
    check("midreset_req_valid", 32'(imem_req_valid), 32'd0);
    check("midreset_pc_out", pc_out, 32'h0);
    check("midreset_ins", instruction_out, NOP);
    model_reset();
    stall = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset        = 1'b0;
    lat_check_en = 1'b1;
    redir_cyc    = cyc - 1;
    lat_armed    = 1'b1;
    repeat (20) drive(1'b0, 1'b1, 1'b0, '0);

    check("enough_pops", 32'(pop_count >= 100), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
